// File: rtl/bringup_pinwalk.sv
// Board bring-up pin walker: drives walking-one/zero, all-toggle or binary-count
// patterns onto a bank of pins, advanced by a prescaler or by single-step requests.
module bringup_pinwalk #(
    parameter int WIDTH           = 15,
    parameter int CLOCKS_PER_STEP = 6000000,
    localparam int IDXW           = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       mode,
    input  logic             hold,
    input  logic             step,
    output logic [WIDTH-1:0] pins,
    output logic [IDXW-1:0]  index,
    output logic             step_pulse,
    output logic             wrap,
    output logic             led_a,
    output logic             led_b
);

    localparam int PSW = (CLOCKS_PER_STEP > 2) ? $clog2(CLOCKS_PER_STEP) : 1;

    typedef enum logic [1:0] {
        MODE_WALK1  = 2'd0,
        MODE_WALK0  = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    logic [PSW-1:0]   prescaler;
    logic             step_q;
    mode_e            mode_q;
    logic             phase;
    logic [WIDTH-1:0] count;

    logic             tick;
    logic             advance;
    logic             restart;
    logic [IDXW-1:0]  index_nx;
    logic             phase_nx;
    logic [WIDTH-1:0] count_nx;
    logic             wrap_nx;

    function automatic logic [WIDTH-1:0] pattern(input mode_e m, input logic [IDXW-1:0] idx,
                                                 input logic ph, input logic [WIDTH-1:0] cnt);
        logic [WIDTH-1:0] onehot;
        onehot = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
        case (m)
            MODE_WALK1:  pattern = onehot;
            MODE_WALK0:  pattern = ~onehot;
            MODE_TOGGLE: pattern = {WIDTH{ph}};
            default:     pattern = cnt;
        endcase
    endfunction

    always_comb begin
        tick     = !hold && (prescaler == PSW'(CLOCKS_PER_STEP - 1));
        advance  = tick || (hold && step && !step_q);
        restart  = (mode_e'(mode) != mode_q);
        index_nx = (index == IDXW'(WIDTH - 1)) ? '0 : index + 1'b1;
        phase_nx = ~phase;
        count_nx = count + 1'b1;
        case (mode_q)
            MODE_TOGGLE: wrap_nx = phase;
            MODE_COUNT:  wrap_nx = &count;
            default:     wrap_nx = (index == IDXW'(WIDTH - 1));
        endcase
    end

    // Next-state values feed the pin pattern directly so step_pulse lines up with new pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler  <= '0;
            step_q     <= 1'b0;
            mode_q     <= MODE_WALK1;
            phase      <= 1'b0;
            count      <= '0;
            index      <= '0;
            pins       <= {{(WIDTH-1){1'b0}}, 1'b1};
            step_pulse <= 1'b0;
            wrap       <= 1'b0;
            led_a      <= 1'b0;
            led_b      <= 1'b1;
        end else begin
            step_q <= step;
            if (restart) begin
                prescaler  <= '0;
                mode_q     <= mode_e'(mode);
                phase      <= 1'b0;
                count      <= '0;
                index      <= '0;
                pins       <= pattern(mode_e'(mode), '0, 1'b0, '0);
                step_pulse <= 1'b0;
                wrap       <= 1'b0;
                led_a      <= 1'b0;
                led_b      <= 1'b1;
            end else begin
                if (!hold) begin
                    prescaler <= tick ? '0 : prescaler + 1'b1;
                end
                step_pulse <= advance;
                wrap       <= advance && wrap_nx;
                if (advance) begin
                    index <= index_nx;
                    phase <= phase_nx;
                    count <= count_nx;
                    led_a <= phase_nx;
                    led_b <= ~phase_nx;
                    pins  <= pattern(mode_q, index_nx, phase_nx, count_nx);
                end
            end
        end
    end

endmodule

// File: tb/tb_bringup_pinwalk.sv
// Directed bench for bringup_pinwalk at WIDTH=4, CLOCKS_PER_STEP=3.
module tb_bringup_pinwalk;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       hold = 1'b0;
    logic       step = 1'b0;
    logic [3:0] pins;
    logic [1:0] index;
    logic       step_pulse;
    logic       wrap;
    logic       led_a;
    logic       led_b;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    bringup_pinwalk #(.WIDTH(4), .CLOCKS_PER_STEP(3)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .mode(mode),
        .hold(hold),
        .step(step),
        .pins(pins),
        .index(index),
        .step_pulse(step_pulse),
        .wrap(wrap),
        .led_a(led_a),
        .led_b(led_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] m, input logic h);
        reset_n = 1'b0;
        mode    = m;
        hold    = h;
        step    = 1'b0;
        cycles(2);
        reset_n = 1'b1;
    endtask

    logic [3:0]  walk0_tab [1:13];
    int unsigned pulses;
    int unsigned wraps;

    initial begin
        walk0_tab = '{4'b1110, 4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1101, 4'b1011,
                      4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b0111, 4'b1110};

        // Reset state and walking-one free run
        reset_n = 1'b0;
        cycles(2);
        check("rst_pins", pins, 4'b0001);
        check("rst_index", index, 0);
        check("rst_led_a", led_a, 0);
        check("rst_led_b", led_b, 1);
        check("rst_pulse", step_pulse, 0);
        check("rst_wrap", wrap, 0);
        reset_n = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            cycles(1);
            check("w1_pins", pins, 4'b0001 << ((c / 3) % 4));
            check("w1_pulse", step_pulse, (c % 3) == 0);
            check("w1_wrap", wrap, c == 12);
        end

        // Walking-zero: restart on first clock after reset release
        do_reset(2'd1, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            cycles(1);
            check("w0_pins", pins, walk0_tab[c]);
            if (c == 1)  check("w0_restart_pulse", step_pulse, 0);
            if (c == 10) check("w0_wrap_no", wrap, 0);
            if (c == 13) check("w0_wrap", wrap, 1);
        end

        // Hold and single-step, then resume from held prescaler value
        do_reset(2'd0, 1'b0);
        cycles(1);
        hold = 1'b1;
        cycles(4);
        check("hold_no_auto", pins, 4'b0001);
        pulses = 0;
        step = 1'b1;
        for (int c = 0; c < 5; c++) begin cycles(1); pulses += step_pulse; end
        step = 1'b0;
        cycles(1); pulses += step_pulse;
        step = 1'b1;
        cycles(1); pulses += step_pulse;
        step = 1'b0;
        cycles(1); pulses += step_pulse;
        check("hold_pulses", pulses, 2);
        check("hold_pins", pins, 4'b0100);
        check("hold_index", index, 2);
        hold = 1'b0;
        cycles(1);
        check("resume_early", step_pulse, 0);
        check("resume_early_pins", pins, 4'b0100);
        cycles(1);
        check("resume_tick", step_pulse, 1);
        check("resume_pins", pins, 4'b1000);
        step = 1'b1;
        cycles(1);
        check("step_ignored", step_pulse, 0);
        check("step_ignored_pins", pins, 4'b1000);
        step = 1'b0;

        // Binary count: 16 advances, single wrap
        do_reset(2'd3, 1'b0);
        cycles(1);
        check("cnt_restart", pins, 4'b0000);
        wraps = 0;
        for (int k = 1; k <= 16; k++) begin
            for (int j = 0; j < 3; j++) begin cycles(1); wraps += wrap; end
            check("cnt_pins", pins, 64'(k % 16));
        end
        check("cnt_wraps", wraps, 1);

        // All-toggle after a mode switch
        mode = 2'd2;
        cycles(1);
        check("tog_restart", pins, 4'b0000);
        check("tog_restart_pulse", step_pulse, 0);
        for (int k = 1; k <= 4; k++) begin
            cycles(3);
            check("tog_pins", pins, (k % 2) ? 4'b1111 : 4'b0000);
            check("tog_wrap", wrap, (k % 2) == 0);
            check("tog_led_a", led_a, k % 2);
            check("tog_led_b", led_b, (k + 1) % 2);
        end

        // Mode change coincident with a tick: restart only
        cycles(2);
        mode = 2'd0;
        cycles(1);
        check("coinc_pins", pins, 4'b0001);
        check("coinc_pulse", step_pulse, 0);
        check("coinc_wrap", wrap, 0);
        check("coinc_index", index, 0);
        cycles(2);
        check("coinc_pre_early", pins, 4'b0001);
        cycles(1);
        check("coinc_next", pins, 4'b0010);
        check("coinc_next_pulse", step_pulse, 1);
        check("pre_reset_led_a", led_a, 1);

        // Asynchronous reset mid-walk
        #2;
        reset_n = 1'b0;
        #1;
        check("async_pins", pins, 4'b0001);
        check("async_led_a", led_a, 0);
        check("async_led_b", led_b, 1);
        check("async_index", index, 0);
        cycles(1);
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
